// File: rtl/gain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gain_arbiter
// Description : Round-robin arbiter that shares one saturating signed Q-format
//               gain multiplier between two FIFO-fed sample channels.
// Revision    : 1.0 - initial release
// ============================================================================
module gain_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT      = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cfg_wr_en,
    input  logic                  cfg_sel,
    input  logic [DATA_WIDTH-1:0] cfg_gain,
    input  logic [DATA_WIDTH-1:0] in0_dout,
    input  logic                  in0_empty,
    output logic                  in0_rd_en,
    input  logic [DATA_WIDTH-1:0] in1_dout,
    input  logic                  in1_empty,
    output logic                  in1_rd_en,
    output logic [DATA_WIDTH-1:0] out0_din,
    output logic                  out0_wr_en,
    input  logic                  out0_full,
    output logic [DATA_WIDTH-1:0] out1_din,
    output logic                  out1_wr_en,
    input  logic                  out1_full,
    output logic                  busy
);

    localparam int                      c_PW     = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0]   c_UNITY  = DATA_WIDTH'(1) << SHIFT;
    localparam logic [DATA_WIDTH-1:0]   c_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]   c_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] r_gain0;
    logic [DATA_WIDTH-1:0] r_gain1;
    logic                  r_last;
    logic                  r_s1_valid;
    logic                  r_s1_ch;
    logic signed [c_PW-1:0] r_s1_prod;
    logic                  r_s2_valid;
    logic                  r_s2_ch;
    logic [DATA_WIDTH-1:0] r_s2_res;

    logic                  w_advance;
    logic                  w_s1_ready;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_grant;
    logic                  w_grant_ch;
    logic [DATA_WIDTH-1:0] w_din;
    logic [DATA_WIDTH-1:0] w_gain;
    logic signed [c_PW-1:0] w_din_x;
    logic signed [c_PW-1:0] w_gain_x;
    logic signed [c_PW-1:0] w_prod;
    logic signed [c_PW-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_sat;

    assign w_advance  = !r_s2_valid || !(r_s2_ch ? out1_full : out0_full);
    assign w_s1_ready = !r_s1_valid || w_advance;

    // Gating eligibility with reset keeps the pop strobes low while reset is held.
    assign w_elig0    = reset && enable && !in0_empty;
    assign w_elig1    = reset && enable && !in1_empty;
    assign w_grant_ch = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
    assign w_grant    = w_s1_ready && (w_elig0 || w_elig1);
    assign in0_rd_en  = w_grant && !w_grant_ch;
    assign in1_rd_en  = w_grant &&  w_grant_ch;

    assign w_din    = w_grant_ch ? in1_dout : in0_dout;
    assign w_gain   = w_grant_ch ? r_gain1  : r_gain0;
    assign w_din_x  = c_PW'($signed(w_din));
    assign w_gain_x = c_PW'($signed(w_gain));
    assign w_prod   = w_din_x * w_gain_x;

    assign w_shifted = r_s1_prod >>> SHIFT;

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (!w_shifted[c_PW-1] && (|w_shifted[c_PW-2:DATA_WIDTH-1])) begin
            w_sat = c_MAX;
        end else if (w_shifted[c_PW-1] && !(&w_shifted[c_PW-2:DATA_WIDTH-1])) begin
            w_sat = c_MIN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gain0    <= c_UNITY;
            r_gain1    <= c_UNITY;
            r_last     <= 1'b1;
            r_s1_valid <= 1'b0;
            r_s1_ch    <= 1'b0;
            r_s1_prod  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_ch    <= 1'b0;
            r_s2_res   <= '0;
        end else begin
            if (cfg_wr_en) begin
                if (cfg_sel) r_gain1 <= cfg_gain;
                else         r_gain0 <= cfg_gain;
            end
            if (w_s1_ready) begin
                r_s1_valid <= w_grant;
                if (w_grant) begin
                    r_s1_ch   <= w_grant_ch;
                    r_s1_prod <= w_prod;
                    r_last    <= w_grant_ch;
                end
            end
            // The result register only moves on advance, so din holds during a stall.
            if (w_advance) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_ch  <= r_s1_ch;
                    r_s2_res <= w_sat;
                end
            end
        end
    end

    assign out0_wr_en = r_s2_valid && !r_s2_ch && !out0_full;
    assign out1_wr_en = r_s2_valid &&  r_s2_ch && !out1_full;
    assign out0_din   = r_s2_res;
    assign out1_din   = r_s2_res;
    assign busy       = r_s1_valid || r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_gain_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gain_arbiter
// Description : Scoreboard bench for gain_arbiter with FIFO models on all sides.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gain_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [31:0] cfg_gain = '0;
    logic [31:0] in0_dout = '0;
    logic        in0_empty = 1'b1;
    logic        in0_rd_en;
    logic [31:0] in1_dout = '0;
    logic        in1_empty = 1'b1;
    logic        in1_rd_en;
    logic [31:0] out0_din;
    logic        out0_wr_en;
    logic        out0_full = 1'b0;
    logic [31:0] out1_din;
    logic        out1_wr_en;
    logic        out1_full = 1'b0;
    logic        busy;

    gain_arbiter #(.DATA_WIDTH(32), .SHIFT(10)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .cfg_wr_en(cfg_wr_en), .cfg_sel(cfg_sel), .cfg_gain(cfg_gain),
        .in0_dout(in0_dout), .in0_empty(in0_empty), .in0_rd_en(in0_rd_en),
        .in1_dout(in1_dout), .in1_empty(in1_empty), .in1_rd_en(in1_rd_en),
        .out0_din(out0_din), .out0_wr_en(out0_wr_en), .out0_full(out0_full),
        .out1_din(out1_din), .out1_wr_en(out1_wr_en), .out1_full(out1_full),
        .busy(busy)
    );

    always #5 clock = ~clock;

    logic [31:0] in0_q[$], in1_q[$], exp0_q[$], exp1_q[$];
    int          pop0_cyc[$], pop1_cyc[$], rd_log[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0, n_pops = 0;
    bit          lat_chk = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load(input int ch, input logic [31:0] din, input logic [31:0] exp);
        if (ch == 0) begin in0_q.push_back(din); exp0_q.push_back(exp); end
        else         begin in1_q.push_back(din); exp1_q.push_back(exp); end
    endtask

    // One clock: drive FIFO heads, observe the decisions taken at the coming edge.
    task automatic cycle();
        @(negedge clock);
        in0_empty = (in0_q.size() == 0);
        in0_dout  = in0_empty ? 32'h0 : in0_q[0];
        in1_empty = (in1_q.size() == 0);
        in1_dout  = in1_empty ? 32'h0 : in1_q[0];
        #1;
        if (in0_rd_en && in1_rd_en) chk("dual_rd", 1, 0);
        if (in0_rd_en) begin
            if (in0_q.size() == 0) chk("rd0_empty", 1, 0);
            else void'(in0_q.pop_front());
            pop0_cyc.push_back(cyc); rd_log.push_back(0); n_pops++;
        end
        if (in1_rd_en) begin
            if (in1_q.size() == 0) chk("rd1_empty", 1, 0);
            else void'(in1_q.pop_front());
            pop1_cyc.push_back(cyc); rd_log.push_back(1); n_pops++;
        end
        if (out0_wr_en) begin
            if (exp0_q.size() == 0) chk("out0_extra", 1, 0);
            else chk("out0_data", out0_din, exp0_q.pop_front());
            if (pop0_cyc.size() != 0) begin
                int p = pop0_cyc.pop_front();
                if (lat_chk) chk("out0_latency", cyc - p, 2);
            end
        end
        if (out1_wr_en) begin
            if (exp1_q.size() == 0) chk("out1_extra", 1, 0);
            else chk("out1_data", out1_din, exp1_q.pop_front());
            if (pop1_cyc.size() != 0) begin
                int p = pop1_cyc.pop_front();
                if (lat_chk) chk("out1_latency", cyc - p, 2);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((in0_q.size() + in1_q.size() + exp0_q.size() + exp1_q.size() != 0 || busy)
               && n < 200) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, (n < 200), 1);
    endtask

    task automatic set_gain(input logic ch, input logic [31:0] g);
        cfg_sel = ch; cfg_gain = g; cfg_wr_en = 1'b1;
        cycle();
        cfg_wr_en = 1'b0;
    endtask

    task automatic clear_all();
        in0_q.delete(); in1_q.delete(); exp0_q.delete(); exp1_q.delete();
        pop0_cyc.delete(); pop1_cyc.delete(); rd_log.delete();
    endtask

    initial begin
        int p5;
        // Reset held with data waiting: nothing may be popped or pushed
        for (int i = 0; i < 4; i++) begin
            load(0, 32'(100 + i), 32'(100 + i));
            load(1, 32'(200 + i), 32'(200 + i));
        end
        repeat (3) cycle();
        chk("rst_rd0", in0_rd_en, 0);
        chk("rst_rd1", in1_rd_en, 0);
        chk("rst_wr0", out0_wr_en, 0);
        chk("rst_wr1", out1_wr_en, 0);
        chk("rst_din0", out0_din, 0);
        chk("rst_din1", out1_din, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // Interleaved round robin from reset, ch0 first, unity gain
        lat_chk = 1'b1;
        drain("rr");
        chk("rr_pops", rd_log.size(), 8);
        for (int i = 0; i < rd_log.size(); i++) chk("rr_order", rd_log[i], i % 2);
        rd_log.delete();

        // Single channel at unity, including the positive extreme
        load(0, 32'd5, 32'd5);
        load(0, -32'sd7, -32'sd7);
        load(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        drain("uni");
        lat_chk = 1'b0;

        // Half gain on ch1 floors toward -inf; ch0 stays unity
        set_gain(1'b1, 32'd512);
        load(1, -32'sd3, -32'sd2);
        load(1, 32'd100, 32'd50);
        load(0, 32'd9, 32'd9);
        drain("half");

        // Gain of two with saturation in both directions
        set_gain(1'b0, 32'd2048);
        load(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        load(0, 32'h8000_0000, 32'h8000_0000);
        load(0, 32'h4000_0000, 32'h7FFF_FFFF);
        load(0, -32'sd5, -32'sd10);
        drain("sat");
        set_gain(1'b0, 32'd1024);
        set_gain(1'b1, 32'd1024);

        // enable low: no grants while data waits
        enable = 1'b0;
        load(0, 32'd77, 32'd77);
        p5 = n_pops;
        repeat (3) cycle();
        chk("dis_no_pop", n_pops - p5, 0);
        chk("dis_idle", busy, 0);
        enable = 1'b1;
        drain("dis");

        // Backpressure on out0 parks the ch0 sample in S2 and blocks both channels
        out0_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load(0, 32'(10 + i), 32'(10 + i));
            load(1, 32'(20 + i), 32'(20 + i));
        end
        repeat (5) cycle();
        p5 = n_pops;
        chk("bp_din5", out0_din, 10);
        chk("bp_wr0", out0_wr_en, 0);
        repeat (5) cycle();
        chk("bp_no_pop", n_pops - p5, 0);
        chk("bp_din10", out0_din, 10);
        chk("bp_busy", busy, 1);
        out0_full = 1'b0;
        drain("bp");

        // Mid-stream reset; gains must return to unity and ch0 wins first
        set_gain(1'b1, 32'd2048);
        for (int i = 0; i < 4; i++) begin
            load(0, 32'(30 + i), 32'(30 + i));
            load(1, 32'(40 + i), 32'(80 + 2 * i));
        end
        repeat (2) cycle();
        reset = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_rd0", in0_rd_en, 0);
        chk("mrst_rd1", in1_rd_en, 0);
        chk("mrst_wr0", out0_wr_en, 0);
        chk("mrst_wr1", out1_wr_en, 0);
        chk("mrst_din0", out0_din, 0);
        chk("mrst_din1", out1_din, 0);
        clear_all();
        repeat (2) cycle();
        reset = 1'b1;
        load(0, 32'd55, 32'd55);
        load(1, 32'd66, 32'd66);
        drain("post");
        chk("post_first", (rd_log.size() != 0) ? rd_log[0] : 9, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
